// File: rtl/fft16_ctrl.sv
// Sequencing controller for the in-place radix-2 DIT FFT butterfly datapath.
// Walks every stage issuing one butterfly per cycle, with drain gaps and a delayed write-back pipe.
module fft16_ctrl #(
   parameter int unsigned LOG2_PTS = 4,
   parameter int unsigned PIPE     = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_inverse,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_rd_en,
   output logic [LOG2_PTS-1:0]   o_rd_addr0,
   output logic [LOG2_PTS-1:0]   o_rd_addr1,
   output logic [LOG2_PTS-2:0]   o_tw_addr,
   output logic                  o_tw_conj,
   output logic                  o_wr_en,
   output logic [LOG2_PTS-1:0]   o_wr_addr0,
   output logic [LOG2_PTS-1:0]   o_wr_addr1,
   output logic [3:0]            o_stage
);

   localparam int unsigned NB     = 1 << (LOG2_PTS - 1);
   localparam int unsigned BW     = LOG2_PTS - 1;
   localparam int unsigned CW     = (PIPE > 1) ? $clog2(PIPE) : 1;
   localparam int unsigned PW     = 1 + 2 * LOG2_PTS;
   localparam logic [3:0]  LAST_S = 4'(LOG2_PTS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       b_q, b_d;
   logic [3:0]          s_q, s_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                conj_q, conj_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_en_q, rd_en_d;
   logic [LOG2_PTS-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [BW-1:0]       tw_q, tw_d;
   logic [3:0]          stage_q, stage_d;
   logic [PW-1:0]       pipe_q [PIPE];
   logic [PW-1:0]       pipe_d [PIPE];
   logic [LOG2_PTS-1:0] bx, span;

   // Stage/butterfly sequencing
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      conj_d  = conj_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_ISSUE;
               b_d     = '0;
               s_d     = '0;
               conj_d  = i_inverse;
            end
         end
         S_ISSUE: begin
            if (b_q == BW'(NB - 1)) begin
               cnt_d   = '0;
               state_d = (s_q == LAST_S) ? S_DRAIN : S_GAP;
            end else begin
               b_d = b_q + BW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(PIPE - 1)) begin
               state_d = S_ISSUE;
               s_d     = s_q + 4'd1;
               b_d     = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == CW'(PIPE - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with the issuing cycle
   always_comb begin
      rd_en_d = (state_d == S_ISSUE);
      busy_d  = (state_d inside {S_ISSUE, S_GAP, S_DRAIN});
      done_d  = (state_d == S_DONE);
      bx      = LOG2_PTS'(b_d);
      span    = LOG2_PTS'(1) << s_d;
      a0_d    = a0_q;
      a1_d    = a1_q;
      tw_d    = tw_q;
      stage_d = stage_q;
      if (rd_en_d) begin
         a0_d    = ((bx >> s_d) << (s_d + 4'd1)) | (bx & (span - LOG2_PTS'(1)));
         a1_d    = a0_d | span;
         tw_d    = b_d << (LAST_S - s_d);
         stage_d = s_d;
      end
      pipe_d[0] = {rd_en_q, a0_q, a1_q};
      for (int i = 1; i < int'(PIPE); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         conj_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_en_q <= 1'b0;
         a0_q    <= '0;
         a1_q    <= '0;
         tw_q    <= '0;
         stage_q <= '0;
         for (int i = 0; i < int'(PIPE); i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         conj_q  <= conj_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_en_q <= rd_en_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         tw_q    <= tw_d;
         stage_q <= stage_d;
         for (int i = 0; i < int'(PIPE); i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_rd_en    = rd_en_q;
   assign o_rd_addr0 = a0_q;
   assign o_rd_addr1 = a1_q;
   assign o_tw_addr  = tw_q;
   assign o_tw_conj  = conj_q;
   assign o_stage    = stage_q;
   assign {o_wr_en, o_wr_addr0, o_wr_addr1} = pipe_q[PIPE-1];

endmodule

// File: tb/tb_fft16_ctrl.sv
// Bench for fft16_ctrl: PIPE=2 and PIPE=1 instances against a schedule model, plus table vectors.
module tb_fft16_ctrl;

   localparam int L  = 4;
   localparam int NB = 8;

   logic i_clk = 1'b0;
   logic i_rst, i_start, i_inverse;

   logic       busy_0, done_0, rd_en_0, conj_0, wr_en_0;
   logic [3:0] a0_0, a1_0, w0_0, w1_0, stage_0;
   logic [2:0] tw_0;
   logic       busy_1, done_1, rd_en_1, conj_1, wr_en_1;
   logic [3:0] a0_1, a1_1, w0_1, w1_1, stage_1;
   logic [2:0] tw_1;

   always #5 i_clk = ~i_clk;

   fft16_ctrl #(.LOG2_PTS(4), .PIPE(2)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_inverse(i_inverse),
      .o_busy(busy_0), .o_done(done_0), .o_rd_en(rd_en_0),
      .o_rd_addr0(a0_0), .o_rd_addr1(a1_0), .o_tw_addr(tw_0), .o_tw_conj(conj_0),
      .o_wr_en(wr_en_0), .o_wr_addr0(w0_0), .o_wr_addr1(w1_0), .o_stage(stage_0));

   fft16_ctrl #(.LOG2_PTS(4), .PIPE(1)) u_dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_inverse(i_inverse),
      .o_busy(busy_1), .o_done(done_1), .o_rd_en(rd_en_1),
      .o_rd_addr0(a0_1), .o_rd_addr1(a1_1), .o_tw_addr(tw_1), .o_tw_conj(conj_1),
      .o_wr_en(wr_en_1), .o_wr_addr0(w0_1), .o_wr_addr1(w1_1), .o_stage(stage_1));

   typedef struct {
      int busy; int done; int rd_en; int a0; int a1; int tw;
      int conj; int stage; int wr_en; int w0; int w1;
   } obs_t;

   typedef struct { int s; int b; int a0; int a1; int tw; } vec_t;

   obs_t act0, act1;
   int   checks = 0;
   int   errors = 0;
   int   exp_conj [2];
   int   wr_cnt [2];
   int   cap_a0 [128];
   int   cap_a1 [128];
   int   cap_tw [128];
   vec_t tbl [$];

   always_comb begin
      act0.busy = int'(busy_0); act0.done = int'(done_0); act0.rd_en = int'(rd_en_0);
      act0.a0 = int'(a0_0); act0.a1 = int'(a1_0); act0.tw = int'(tw_0);
      act0.conj = int'(conj_0); act0.stage = int'(stage_0); act0.wr_en = int'(wr_en_0);
      act0.w0 = int'(w0_0); act0.w1 = int'(w1_0);
      act1.busy = int'(busy_1); act1.done = int'(done_1); act1.rd_en = int'(rd_en_1);
      act1.a0 = int'(a0_1); act1.a1 = int'(a1_1); act1.tw = int'(tw_1);
      act1.conj = int'(conj_1); act1.stage = int'(stage_1); act1.wr_en = int'(wr_en_1);
      act1.w0 = int'(w0_1); act1.w1 = int'(w1_1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Cycle u (1-based after the start cycle) issues butterfly b of stage s?
   function automatic bit issue_at(input int p, input int u, output int s, output int b);
      int per;
      per = NB + p;
      s = 0;
      b = 0;
      if (u < 1 || u > L * per) return 1'b0;
      s = (u - 1) / per;
      b = (u - 1) % per;
      return (b < NB);
   endfunction

   function automatic void addr_of(input int s, input int b, output int a0, output int a1, output int tw);
      int span, grp, pos;
      span = 2 ** s;
      grp  = b / span;
      pos  = b % span;
      a0   = grp * 2 * span + pos;
      a1   = a0 + span;
      tw   = pos * (NB / span);
   endfunction

   function automatic int total_of(input int p);
      return L * (NB + p) + 1;
   endfunction

   function automatic obs_t model(input int p, input int t, input bit held, input int conj);
      obs_t e;
      int tt, s, b, a0, a1, tw;
      e = '{default: 0};
      tt = held ? t % (total_of(p) + 1) : t;
      e.busy = (tt >= 1 && tt <= L * (NB + p)) ? 1 : 0;
      e.done = (tt == total_of(p)) ? 1 : 0;
      e.conj = conj;
      if (issue_at(p, tt, s, b)) begin
         addr_of(s, b, a0, a1, tw);
         e.rd_en = 1; e.a0 = a0; e.a1 = a1; e.tw = tw; e.stage = s;
      end
      if (issue_at(p, tt - p, s, b)) begin
         addr_of(s, b, a0, a1, tw);
         e.wr_en = 1; e.w0 = a0; e.w1 = a1;
      end
      return e;
   endfunction

   function automatic bit idle_at(input int p, input int t, input bit held);
      if (held) return (t % (total_of(p) + 1)) == 0;
      return t > total_of(p);
   endfunction

   task automatic cmp(input int d, input int t, input obs_t a, input obs_t e);
      string pre;
      pre = $sformatf("d%0d_t%0d", d, t);
      chk({pre, "_busy"}, a.busy, e.busy);
      chk({pre, "_done"}, a.done, e.done);
      chk({pre, "_rd_en"}, a.rd_en, e.rd_en);
      chk({pre, "_wr_en"}, a.wr_en, e.wr_en);
      chk({pre, "_conj"}, a.conj, e.conj);
      if (e.rd_en != 0) begin
         chk({pre, "_rd_addr0"}, a.a0, e.a0);
         chk({pre, "_rd_addr1"}, a.a1, e.a1);
         chk({pre, "_tw_addr"}, a.tw, e.tw);
         chk({pre, "_stage"}, a.stage, e.stage);
      end
      if (e.wr_en != 0) begin
         chk({pre, "_wr_addr0"}, a.w0, e.w0);
         chk({pre, "_wr_addr1"}, a.w1, e.w1);
      end
      if (a.wr_en != 0) wr_cnt[d]++;
   endtask

   task automatic chk_zero(input int d, input obs_t a, input string tag);
      string pre;
      pre = $sformatf("%s_d%0d", tag, d);
      chk({pre, "_busy"}, a.busy, 0);   chk({pre, "_done"}, a.done, 0);
      chk({pre, "_rd_en"}, a.rd_en, 0); chk({pre, "_wr_en"}, a.wr_en, 0);
      chk({pre, "_rd_addr0"}, a.a0, 0); chk({pre, "_rd_addr1"}, a.a1, 0);
      chk({pre, "_tw_addr"}, a.tw, 0);  chk({pre, "_stage"}, a.stage, 0);
      chk({pre, "_wr_addr0"}, a.w0, 0); chk({pre, "_wr_addr1"}, a.w1, 0);
      chk({pre, "_conj"}, a.conj, 0);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Caller is one cycle into IDLE; that cycle becomes cycle 0 of the run.
   task automatic run(input int ncyc, input bit held);
      obs_t e;
      wr_cnt[0] = 0;
      wr_cnt[1] = 0;
      for (int i = 0; i < 128; i++) begin
         cap_a0[i] = -1; cap_a1[i] = -1; cap_tw[i] = -1;
      end
      i_start   = 1'b1;
      i_inverse = 1'($urandom % 2);
      exp_conj[0] = int'(i_inverse);
      exp_conj[1] = int'(i_inverse);
      for (int t = 1; t <= ncyc; t++) begin
         step();
         e = model(2, t, held, exp_conj[0]);
         cmp(0, t, act0, e);
         if (t < 128 && act0.rd_en != 0) begin
            cap_a0[t] = act0.a0; cap_a1[t] = act0.a1; cap_tw[t] = act0.tw;
         end
         e = model(1, t, held, exp_conj[1]);
         cmp(1, t, act1, e);
         i_start   = held ? 1'b1 : ((t <= 35) ? 1'($urandom % 2) : 1'b0);
         i_inverse = 1'($urandom % 2);
         if (i_start && idle_at(2, t, held)) exp_conj[0] = int'(i_inverse);
         if (i_start && idle_at(1, t, held)) exp_conj[1] = int'(i_inverse);
      end
   endtask

   task automatic table_check(input string tag);
      int cyc;
      foreach (tbl[i]) begin
         cyc = 1 + tbl[i].s * (NB + 2) + tbl[i].b;
         chk($sformatf("%s_s%0d_b%0d_rd0", tag, tbl[i].s, tbl[i].b), cap_a0[cyc], tbl[i].a0);
         chk($sformatf("%s_s%0d_b%0d_rd1", tag, tbl[i].s, tbl[i].b), cap_a1[cyc], tbl[i].a1);
         chk($sformatf("%s_s%0d_b%0d_tw", tag, tbl[i].s, tbl[i].b), cap_tw[cyc], tbl[i].tw);
      end
   endtask

   initial begin
      tbl.push_back('{0, 0, 0, 1, 0}); tbl.push_back('{0, 1, 2, 3, 0});
      tbl.push_back('{0, 2, 4, 5, 0}); tbl.push_back('{0, 3, 6, 7, 0});
      tbl.push_back('{1, 0, 0, 2, 0}); tbl.push_back('{1, 1, 1, 3, 4});
      tbl.push_back('{1, 2, 4, 6, 0});
      tbl.push_back('{2, 0, 0, 4, 0}); tbl.push_back('{2, 1, 1, 5, 2});
      tbl.push_back('{2, 2, 2, 6, 4}); tbl.push_back('{2, 3, 3, 7, 6});
      tbl.push_back('{2, 4, 8, 12, 0});
      for (int b = 0; b < 8; b++) tbl.push_back('{3, b, b, b + 8, b});

      i_rst = 1'b1; i_start = 1'b0; i_inverse = 1'b0;
      exp_conj[0] = 0; exp_conj[1] = 0;
      #12;
      chk_zero(0, act0, "reset");
      chk_zero(1, act1, "reset");
      step();
      i_rst = 1'b0;
      step();

      run(45, 1'b0);
      table_check("run1");
      chk("run1_wr_count_p2", wr_cnt[0], 32);
      chk("run1_wr_count_p1", wr_cnt[1], 32);

      repeat (3) begin
         repeat ($urandom_range(0, 3)) step();
         run(45, 1'b0);
         chk("rnd_wr_count_p2", wr_cnt[0], 32);
         chk("rnd_wr_count_p1", wr_cnt[1], 32);
      end

      run(90, 1'b1);
      i_start = 1'b0;
      i_rst = 1'b1;
      #1;
      exp_conj[0] = 0; exp_conj[1] = 0;
      chk_zero(0, act0, "held_rst");
      chk_zero(1, act1, "held_rst");
      step();
      i_rst = 1'b0;
      step();

      run(14, 1'b0);
      i_start = 1'b0;
      step();
      #3 i_rst = 1'b1;
      #1;
      exp_conj[0] = 0; exp_conj[1] = 0;
      chk_zero(0, act0, "abort");
      chk_zero(1, act1, "abort");
      step();
      i_rst = 1'b0;
      for (int t = 0; t < 50; t++) begin
         step();
         chk($sformatf("abort_t%0d_wr_en_p2", t), act0.wr_en, 0);
         chk($sformatf("abort_t%0d_wr_en_p1", t), act1.wr_en, 0);
         chk($sformatf("abort_t%0d_done_p2", t), act0.done, 0);
         chk($sformatf("abort_t%0d_done_p1", t), act1.done, 0);
         chk($sformatf("abort_t%0d_busy_p2", t), act0.busy, 0);
      end

      run(45, 1'b0);
      table_check("rerun");
      chk("rerun_wr_count_p2", wr_cnt[0], 32);
      chk("rerun_wr_count_p1", wr_cnt[1], 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft16_ctrl.md
# fft16_ctrl

Sequencing controller for the radix-2 butterfly datapath (`butterfly2`) in the in-place 16-point FFT. On a start pulse it walks all log2(points) stages, issuing one butterfly per cycle: two operand read addresses to the sample RAM, a twiddle ROM index, and PIPE-cycle-delayed write-back addresses with write enable. It inserts drain gaps between stages so no read precedes the write of the same stage's results, then pulses done. Input samples are stored in bit-reversed order (DIT).

## Interface
- LOG2_PTS, 4, log2 of FFT points; stages = LOG2_PTS, butterflies/stage = 2^(LOG2_PTS-1)
- PIPE, 2, cycles from read-address issue to write-back of that butterfly (RAM read + butterfly register); legal ≥1

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  begin a transform; sampled only in IDLE
- i_inverse  in  1  latched at accepted start; drives o_tw_conj for the whole run
- o_busy  out  1  high from first issue cycle through last write cycle
- o_done  out  1  one-cycle pulse after last write
- o_rd_en  out  1  operand read valid this cycle
- o_rd_addr0, o_rd_addr1  out  LOG2_PTS  operand addresses (top/bottom)
- o_tw_addr  out  LOG2_PTS-1  twiddle index k, W=exp(-j2πk/2^LOG2_PTS)
- o_tw_conj  out  1  conjugate twiddle (inverse FFT)
- o_wr_en  out  1  write-back valid
- o_wr_addr0, o_wr_addr1  out  LOG2_PTS  write-back addresses (in place)
- o_stage  out  4  stage of the butterfly currently issued

## Operation
- States: IDLE, ISSUE, GAP, DRAIN, DONE.
- IDLE: i_start=1 → ISSUE, stage=0, b=0, latch i_inverse. Otherwise stay.
- ISSUE: o_rd_en=1; for stage s, butterfly b: span=2^s, grp=b>>s, pos=b&(span-1); rd_addr0=grp·2·span+pos; rd_addr1=rd_addr0+span; tw_addr=pos<<(LOG2_PTS-1-s). b increments per cycle. At b=last: if s<LOG2_PTS-1 → GAP, else → DRAIN.
- GAP: o_rd_en=0 for exactly PIPE cycles, then ISSUE with s+1, b=0.
- DRAIN: o_rd_en=0 until the final write is issued (PIPE cycles), then DONE.
- DONE: o_done=1 one cycle, o_busy=0, → IDLE. i_start ignored in DONE.
- Write pipeline: PIPE-deep shift of {rd_en, rd_addr0, rd_addr1}; o_wr_en/o_wr_addr* are its output, independent of state.
- i_start while not IDLE: ignored, no restart, no effect on latched i_inverse.
- o_rd_addr*, o_tw_addr, o_stage hold last value when o_rd_en=0 (don't care to consumers, but held for determinism).

## Timing
- Reset (async assert): state IDLE; all outputs 0; write pipeline valid bits cleared, so no write from an aborted run ever appears. Reset mid-run aborts; next start runs a full transform.
- i_start high in cycle 0 (IDLE) → first issue in cycle 1.
- Issue cycles per stage 2^(LOG2_PTS-1); gap PIPE; last write = last issue + PIPE.
- LOG2_PTS=4, PIPE=2: stage issues cycles 1–8, 11–18, 21–28, 31–38; writes cycles 3–10, 13–20, 23–30, 33–40; o_busy cycles 1–40; o_done cycle 41; IDLE again cycle 42 (start accepted then).
- Hazard rule: first read of stage s+1 occurs one cycle after last write of stage s.
- Total latency start→done = LOG2_PTS·2^(LOG2_PTS-1) + LOG2_PTS·PIPE + 1 cycles (41 for defaults).

## Test plan
- Stage sequences (defaults): s0 b0..3 → (0,1,k0),(2,3,k0),(4,5,k0),(6,7,k0); s1 b0..2 → (0,2,k0),(1,3,k4),(4,6,k0); s2 b0..4 → (0,4,k0),(1,5,k2),(2,6,k4),(3,7,k6),(8,12,k0); s3 b → (b,b+8,k=b).
- Write-back: every o_wr_en cycle, o_wr_addr0/1 equal rd_addr0/1 of exactly 2 cycles earlier; 32 write cycles total; none outside cycles 3–40.
- Timing: start cycle 0 → o_busy 1–40, o_rd_en low cycles 9–10, 19–20, 29–30, o_done only in cycle 41; o_stage 0/1/2/3 in respective issue windows.
- Start held high continuously from cycle 0: exactly one run, next run's first issue cycle 43; i_inverse toggled mid-run → o_tw_conj unchanged.
- Reset asserted cycle 15 (async, mid-edge): outputs 0 immediately, no o_wr_en afterwards, no o_done; new start gives full sequence identical to test 1.
- PIPE=1 build: gaps 1 cycle, o_done cycle 37, write address lag 1 cycle.
